// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_arb_pkg
// Brief    : Shared state encoding and grant constants for the write arbiter.
// Revision : 1.0
// ============================================================================
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/axi_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_arbiter_if
// Brief    : Master/slave handshake bundle around the two-master write arbiter.
// Revision : 1.0
// ============================================================================
interface axi_write_arbiter_if;

    logic M0_AWVALID, M1_AWVALID;
    logic M0_WVALID,  M1_WVALID;
    logic M0_WLAST,   M1_WLAST;
    logic M0_BREADY,  M1_BREADY;
    logic S_AWREADY,  S_WREADY,  S_BVALID;

    logic sel;
    logic enable;
    logic S_AWVALID,  S_WVALID,  S_BREADY;
    logic M0_AWREADY, M1_AWREADY;
    logic M0_WREADY,  M1_WREADY;
    logic M0_BVALID,  M1_BVALID;

    // Arbiter side
    modport slave (
        input  M0_AWVALID, M1_AWVALID, M0_WVALID, M1_WVALID,
        input  M0_WLAST, M1_WLAST, M0_BREADY, M1_BREADY,
        input  S_AWREADY, S_WREADY, S_BVALID,
        output sel, enable, S_AWVALID, S_WVALID, S_BREADY,
        output M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY,
        output M0_BVALID, M1_BVALID
    );

    // Environment side (masters and slave together)
    modport master (
        output M0_AWVALID, M1_AWVALID, M0_WVALID, M1_WVALID,
        output M0_WLAST, M1_WLAST, M0_BREADY, M1_BREADY,
        output S_AWREADY, S_WREADY, S_BVALID,
        input  sel, enable, S_AWVALID, S_WVALID, S_BREADY,
        input  M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY,
        input  M0_BVALID, M1_BVALID
    );

endinterface
`default_nettype wire

// File: rtl/axi_write_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Two-requester winner selection, round-robin or M0-fixed priority.
// Revision : 1.0
// ============================================================================
module rr_pick2
    import axi_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        winner  = GRANT_M0;
        if (req == 2'b11) begin
            // On a tie the master that did not hold the previous grant goes next
            winner = (FIXED_PRIO != 0) ? GRANT_M0 : ~last_grant;
        end else if (req[1]) begin
            winner = GRANT_M1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_arbiter
// Brief    : Holds one master's grant from AW through last W beat and B response.
// Revision : 1.0
// ============================================================================
module axi_write_arbiter
    import axi_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    axi_write_arbiter_if.slave   bus
);

    arb_state_t state;
    arb_state_t next_state;
    logic       grant_sel;
    logic       grant_en;
    logic       last_grant;
    logic       winner;
    logic       any_req;

    logic       aw_valid_g;
    logic       w_valid_g;
    logic       w_last_g;
    logic       b_ready_g;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req        ({bus.M1_AWVALID, bus.M0_AWVALID}),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign aw_valid_g = grant_sel ? bus.M1_AWVALID : bus.M0_AWVALID;
    assign w_valid_g  = grant_sel ? bus.M1_WVALID  : bus.M0_WVALID;
    assign w_last_g   = grant_sel ? bus.M1_WLAST   : bus.M0_WLAST;
    assign b_ready_g  = grant_sel ? bus.M1_BREADY  : bus.M0_BREADY;

    assign aw_hs = (state == ADDR) && aw_valid_g && bus.S_AWREADY;
    assign w_hs  = (state == DATA) && w_valid_g  && bus.S_WREADY;
    assign b_hs  = (state == RESP) && b_ready_g  && bus.S_BVALID;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req)           next_state = ADDR;
            ADDR:    if (aw_hs)             next_state = DATA;
            DATA:    if (w_hs && w_last_g)  next_state = RESP;
            RESP:    if (b_hs)              next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    // last_grant resets to M1 so the very first tie goes to M0
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            grant_sel  <= GRANT_M0;
            grant_en   <= 1'b0;
            last_grant <= GRANT_M1;
        end else if ((state == IDLE) && any_req) begin
            grant_sel  <= winner;
            grant_en   <= 1'b1;
        end else if (b_hs) begin
            grant_en   <= 1'b0;
            last_grant <= grant_sel;
        end
    end

    assign bus.sel    = grant_sel;
    assign bus.enable = grant_en;

    always_comb begin
        bus.S_AWVALID  = 1'b0;
        bus.S_WVALID   = 1'b0;
        bus.S_BREADY   = 1'b0;
        bus.M0_AWREADY = 1'b0;
        bus.M1_AWREADY = 1'b0;
        bus.M0_WREADY  = 1'b0;
        bus.M1_WREADY  = 1'b0;
        bus.M0_BVALID  = 1'b0;
        bus.M1_BVALID  = 1'b0;
        case (state)
            ADDR: begin
                bus.S_AWVALID = aw_valid_g;
                if (grant_sel == GRANT_M1) bus.M1_AWREADY = bus.S_AWREADY;
                else                       bus.M0_AWREADY = bus.S_AWREADY;
            end
            DATA: begin
                bus.S_WVALID = w_valid_g;
                if (grant_sel == GRANT_M1) bus.M1_WREADY = bus.S_WREADY;
                else                       bus.M0_WREADY = bus.S_WREADY;
            end
            RESP: begin
                bus.S_BREADY = b_ready_g;
                if (grant_sel == GRANT_M1) bus.M1_BVALID = bus.S_BVALID;
                else                       bus.M0_BVALID = bus.S_BVALID;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_write_arbiter
// Brief    : Directed vector table plus multi-cycle sequences for the arbiter.
// Revision : 1.0
// ============================================================================
module tb_axi_write_arbiter;

    typedef struct packed {
        logic       rst;
        logic [1:0] awv;    // {M1, M0}
        logic [1:0] wv;
        logic [1:0] wl;
        logic [1:0] br;
        logic       saw;
        logic       sw;
        logic       sb;
        logic       e_sel;
        logic       e_en;
        logic [2:0] e_s;    // {S_AWVALID, S_WVALID, S_BREADY}
        logic [5:0] e_m;    // {M1_AWREADY, M0_AWREADY, M1_WREADY, M0_WREADY, M1_BVALID, M0_BVALID}
    } vec_t;

    localparam int NVEC = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axi_write_arbiter_if bus0 ();
    axi_write_arbiter_if bus1 ();

    axi_write_arbiter #(.FIXED_PRIO(0)) u_dut0 (.ACLK(clk), .ARESET(rst), .bus(bus0));
    axi_write_arbiter #(.FIXED_PRIO(1)) u_dut1 (.ACLK(clk), .ARESET(rst), .bus(bus1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive0(input logic [1:0] awv, input logic [1:0] wv, input logic [1:0] wl,
                          input logic [1:0] br, input logic saw, input logic sw, input logic sb);
        {bus0.M1_AWVALID, bus0.M0_AWVALID} = awv;
        {bus0.M1_WVALID,  bus0.M0_WVALID}  = wv;
        {bus0.M1_WLAST,   bus0.M0_WLAST}   = wl;
        {bus0.M1_BREADY,  bus0.M0_BREADY}  = br;
        bus0.S_AWREADY = saw;
        bus0.S_WREADY  = sw;
        bus0.S_BVALID  = sb;
    endtask

    task automatic drive1(input logic [1:0] awv, input logic [1:0] wv, input logic [1:0] wl,
                          input logic [1:0] br, input logic saw, input logic sw, input logic sb);
        {bus1.M1_AWVALID, bus1.M0_AWVALID} = awv;
        {bus1.M1_WVALID,  bus1.M0_WVALID}  = wv;
        {bus1.M1_WLAST,   bus1.M0_WLAST}   = wl;
        {bus1.M1_BREADY,  bus1.M0_BREADY}  = br;
        bus1.S_AWREADY = saw;
        bus1.S_WREADY  = sw;
        bus1.S_BVALID  = sb;
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] awv, input logic [1:0] wv,
                                input logic [1:0] wl, input logic [1:0] br, input logic saw,
                                input logic sw, input logic sb, input logic es, input logic ee,
                                input logic [2:0] s, input logic [5:0] m);
        vec_t v;
        v.rst = r;  v.awv = awv; v.wv = wv; v.wl = wl; v.br = br;
        v.saw = saw; v.sw = sw; v.sb = sb;
        v.e_sel = es; v.e_en = ee; v.e_s = s; v.e_m = m;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive0(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        drive1(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs [NVEC];

    initial begin
        int aw_rdy, w_rdy, b_vld, m0_any, sel_bad, idle_at, beats;
        logic aw_done;
        logic prev0, prev1;
        int g0, g1;

        drive0(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        drive1(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        //            rst awv    wv     wl     br     saw  sw   sb   sel  en   s       m
        vecs[0]  = mk(1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 3'b000, 6'b000000);
        vecs[1]  = mk(1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 3'b000, 6'b000000);
        vecs[2]  = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 3'b000, 6'b000000);
        vecs[3]  = mk(0, 2'b11, 2'b01, 2'b00, 2'b00, 1, 1, 0, 0, 1, 3'b100, 6'b010000);
        vecs[4]  = mk(0, 2'b10, 2'b01, 2'b01, 2'b00, 0, 1, 0, 0, 1, 3'b010, 6'b000100);
        vecs[5]  = mk(0, 2'b10, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 3'b001, 6'b000000);
        vecs[6]  = mk(0, 2'b10, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 1, 3'b001, 6'b000001);
        vecs[7]  = mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 3'b000, 6'b000000);
        vecs[8]  = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 1, 3'b100, 6'b000000);
        vecs[9]  = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 1, 3'b000, 6'b100000);
        vecs[10] = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 1, 3'b100, 6'b100000);
        vecs[11] = mk(0, 2'b01, 2'b11, 2'b00, 2'b00, 0, 1, 0, 1, 1, 3'b010, 6'b001000);
        vecs[12] = mk(0, 2'b01, 2'b10, 2'b10, 2'b00, 0, 0, 0, 1, 1, 3'b010, 6'b000000);
        vecs[13] = mk(0, 2'b01, 2'b00, 2'b10, 2'b00, 0, 1, 0, 1, 1, 3'b000, 6'b001000);
        vecs[14] = mk(0, 2'b01, 2'b10, 2'b10, 2'b00, 0, 1, 0, 1, 1, 3'b010, 6'b001000);
        vecs[15] = mk(0, 2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 1, 1, 1, 3'b001, 6'b000010);
        vecs[16] = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 3'b000, 6'b000000);
        vecs[17] = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 3'b100, 6'b010000);
        vecs[18] = mk(0, 2'b11, 2'b01, 2'b01, 2'b00, 0, 1, 0, 0, 1, 3'b010, 6'b000100);
        vecs[19] = mk(0, 2'b11, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 1, 3'b001, 6'b000001);
        vecs[20] = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b000, 6'b000000);
        vecs[21] = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 1, 3'b100, 6'b100000);
        vecs[22] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 1, 0, 1, 1, 3'b010, 6'b001000);
        vecs[23] = mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 1, 0, 1, 1, 3'b010, 6'b001000);
        vecs[24] = mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 1, 0, 0, 0, 3'b000, 6'b000000);
        vecs[25] = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 3'b000, 6'b000000);
        vecs[26] = mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 3'b100, 6'b000000);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            drive0(vecs[i].awv, vecs[i].wv, vecs[i].wl, vecs[i].br,
                   vecs[i].saw, vecs[i].sw, vecs[i].sb);
            #1;
            chk($sformatf("v%0d_sel", i), 32'(bus0.sel), 32'(vecs[i].e_sel));
            chk($sformatf("v%0d_enable", i), 32'(bus0.enable), 32'(vecs[i].e_en));
            chk($sformatf("v%0d_slave_side", i),
                32'({bus0.S_AWVALID, bus0.S_WVALID, bus0.S_BREADY}), 32'(vecs[i].e_s));
            chk($sformatf("v%0d_master_side", i),
                32'({bus0.M1_AWREADY, bus0.M0_AWREADY, bus0.M1_WREADY,
                     bus0.M0_WREADY, bus0.M1_BVALID, bus0.M0_BVALID}), 32'(vecs[i].e_m));
        end

        // Single M1 4-beat burst, slave always ready
        do_reset();
        @(negedge clk);
        drive0(2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1);
        #1;
        chk("burst_pre_grant_enable", 32'(bus0.enable), 32'd0);
        aw_rdy = 0; w_rdy = 0; b_vld = 0; m0_any = 0; sel_bad = 0; idle_at = 0;
        beats = 0; aw_done = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            drive0({~aw_done, 1'b0}, {aw_done && (beats < 4), 1'b0},
                   {beats == 3, 1'b0}, 2'b10, 1'b1, 1'b1, 1'b1);
            #1;
            if (bus0.enable && (bus0.sel !== 1'b1)) sel_bad++;
            if (bus0.M0_AWREADY || bus0.M0_WREADY || bus0.M0_BVALID) m0_any++;
            if (bus0.M1_AWREADY) aw_rdy++;
            if (bus0.M1_WREADY)  w_rdy++;
            if (bus0.M1_BVALID)  b_vld++;
            if (bus0.M1_AWREADY && bus0.M1_AWVALID) aw_done = 1'b1;
            if (bus0.M1_WREADY && bus0.M1_WVALID) beats++;
            if (!bus0.enable && (idle_at == 0)) idle_at = c;
        end
        chk("burst_awready_cycles", 32'(aw_rdy), 32'd1);
        chk("burst_wready_cycles", 32'(w_rdy), 32'd4);
        chk("burst_bvalid_cycles", 32'(b_vld), 32'd1);
        chk("burst_m0_ready_cycles", 32'(m0_any), 32'd0);
        chk("burst_sel_not_m1", 32'(sel_bad), 32'd0);
        chk("burst_idle_cycle", 32'(idle_at), 32'd7);

        // W presented before AW, then a B stall with M1 waiting
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive0(2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1);
            #1;
            chk($sformatf("early_w_wready_%0d", c), 32'(bus0.M0_WREADY), 32'd0);
        end
        @(negedge clk);
        drive0(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1);
        #1;
        chk("early_w_idle_wready", 32'(bus0.M0_WREADY), 32'd0);
        @(negedge clk);
        drive0(2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1);
        #1;
        chk("early_w_addr_wready", 32'(bus0.M0_WREADY), 32'd0);
        chk("early_w_addr_awready", 32'(bus0.M0_AWREADY), 32'd1);
        @(negedge clk);
        drive0(2'b00, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
        #1;
        chk("early_w_data_wready", 32'(bus0.M0_WREADY), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive0(2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0);
            #1;
            chk($sformatf("bstall_%0d_state", c),
                32'({bus0.enable, bus0.sel, bus0.S_BREADY, bus0.M0_BVALID, bus0.M1_AWREADY}),
                32'(5'b10100));
        end
        @(negedge clk);
        drive0(2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1);
        #1;
        chk("bstall_release_bvalid", 32'(bus0.M0_BVALID), 32'd1);
        @(negedge clk);
        drive0(2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
        #1;
        chk("bstall_idle_enable", 32'(bus0.enable), 32'd0);
        @(negedge clk);
        #1;
        chk("bstall_m1_grant", 32'({bus0.enable, bus0.sel}), 32'(2'b11));

        // Continuous contention: round-robin on dut0, fixed priority on dut1
        do_reset();
        prev0 = 1'b0; prev1 = 1'b0; g0 = 0; g1 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            drive0(2'b11, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1);
            drive1(2'b11, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1);
            #1;
            if (bus0.enable && !prev0) begin
                chk($sformatf("rr_grant%0d_sel", g0), 32'(bus0.sel), 32'(g0 % 2));
                g0++;
            end
            if (bus1.enable && !prev1) begin
                chk($sformatf("fixed_grant%0d_sel", g1), 32'(bus1.sel), 32'd0);
                g1++;
            end
            prev0 = bus0.enable;
            prev1 = bus1.enable;
        end
        chk("rr_grant_count", 32'(g0), 32'd5);
        chk("fixed_grant_count", 32'(g1), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Two-master write-channel arbiter for the AXI interconnect. It sits directly upstream of the AW/W/B payload muxes and drives their `sel`/`enable` pair, choosing one master per write transaction. It holds the grant from the AW handshake through the last W beat and the B response. It gates the per-master VALID/READY handshake signals so that only the granted master sees the slave.

## Interface
Parameters:
- `FIXED_PRIO`, default 0: 0 = round-robin between M0/M1; 1 = M0 always wins a tie.

Ports:
- `ACLK` in 1: single clock; all state updates on rising edge.
- `ARESET` in 1: asynchronous, active-high reset.
- `M0_AWVALID`, `M1_AWVALID` in 1 each: per-master write-address request.
- `M0_WVALID`, `M1_WVALID` in 1 each: per-master write-data valid.
- `M0_WLAST`, `M1_WLAST` in 1 each: per-master last beat.
- `M0_BREADY`, `M1_BREADY` in 1 each: per-master response ready.
- `S_AWREADY`, `S_WREADY`, `S_BVALID` in 1 each: slave-side handshakes.
- `sel` out 1: mux select; 0 = M0, 1 = M1. Registered.
- `enable` out 1: mux enable; 1 while a grant is held. Registered.
- `S_AWVALID`, `S_WVALID`, `S_BREADY` out 1 each: gated toward the slave.
- `M0_AWREADY`, `M1_AWREADY`, `M0_WREADY`, `M1_WREADY`, `M0_BVALID`, `M1_BVALID` out 1 each: gated toward the masters.

## Operation
- The FSM has four states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any `Mx_AWVALID` is high, register the winner into `sel`, set `enable`=1, and go to ADDR.
  - Otherwise stay in IDLE with `enable`=0. `sel` holds its last value.
- Pick rule when both masters request:
  - `FIXED_PRIO`=1: M0 wins.
  - `FIXED_PRIO`=0: the master not granted last (`last_grant` register) wins.
  - A single requester always wins.
- ADDR:
  - `S_AWVALID` = `AWVALID` of the granted master.
  - Granted master's `AWREADY` = `S_AWREADY`.
  - When both are high (handshake), go to DATA.
- DATA:
  - `S_WVALID` = granted `WVALID`.
  - Granted master's `WREADY` = `S_WREADY`.
  - A handshake with granted `WLAST`=1 moves to RESP. Other beats stay in DATA.
- RESP:
  - `S_BREADY` = granted `BREADY`.
  - Granted master's `BVALID` = `S_BVALID`.
  - When both are high, go to IDLE. `enable` drops to 0 and `last_grant` ← `sel`.
- Outside the matching state, every gated output is 0. The non-granted master's READY/BVALID outputs are always 0.
- W beats presented before the grant are stalled (`WREADY`=0). AW is always accepted before W.
- Requests that arrive during ADDR/DATA/RESP are ignored until IDLE. There is no pre-emption.
- A request that is deasserted in ADDR before the handshake keeps the grant. The FSM waits in ADDR; this is legal only under AXI's no-retract rule.

## Timing
- Reset values: state IDLE, `sel`=0, `enable`=0, `last_grant`=1 (so M0 wins the first tie), all gated outputs 0.
- `ARESET` mid-transaction returns everything to reset values asynchronously. The in-flight burst is abandoned.
- Grant latency: request sampled at edge N → `sel`/`enable` valid after edge N, and ADDR gating is live in cycle N+1.
- Minimum transaction, 1-beat burst with all handshakes ready immediately:
  - IDLE → ADDR → DATA → RESP → IDLE.
  - That is 4 cycles from request to next arbitration opportunity.
- A back-to-back request from the other master is granted on the IDLE cycle after RESP. This gives a one-cycle bubble per transaction.
- Gated outputs are combinational from the registered state and `sel` plus the current inputs. There is no combinational path from `Mx_AWVALID` to `sel`/`enable`.

## Structure
- Shared package `axi_arb_pkg`:
  - state enum `arb_state_t` (IDLE=2'd0, ADDR=2'd1, DATA=2'd2, RESP=2'd3);
  - constants `GRANT_M0`=1'b0 and `GRANT_M1`=1'b1.
- Sub-module `rr_pick2`: combinational winner selection from `req[1:0]`, `last_grant`, and `FIXED_PRIO`. Outputs `winner` and `any_req`.
- `axi_write_arbiter` holds the FSM, the `sel`/`enable`/`last_grant` registers, and the handshake gating.

## Test plan
- Reset: hold `ARESET`=1 with both AWVALID high → `sel`=0, `enable`=0, all gated outputs 0. Release → M0 granted (`sel`=0, `enable`=1) after the next edge.
- Single M1 4-beat burst, slave always ready:
  - `sel`=1 throughout; `M1_AWREADY` high for 1 cycle and `M1_WREADY` high for 4 cycles;
  - back to IDLE 7 cycles after the grant edge;
  - `M0_*READY` stay 0.
- Both masters request continuously, `FIXED_PRIO`=0 → grants alternate M0, M1, M0, M1. With `FIXED_PRIO`=1 → M0 every time.
- W before AW: `M0_WVALID`=1 two cycles before `M0_AWVALID` → `M0_WREADY`=0 until the AW handshake completes.
- Slave stalls `S_BVALID` for 5 cycles in RESP → the FSM holds RESP, `enable`=1, and the M1 request is not granted until after the B handshake.
- Assert `ARESET` in DATA after 2 of 4 beats → `enable`=0 immediately, state IDLE. The next tie grants M0.
